// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RISC-V controller: states, opcodes, mux selects, ALU codes.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Build option ILLEGAL_TRAP_EN enables the TRAP state in the controller.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        JAL      = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_alu_ctl.sv
// ALU control decode: alu_op plus funct fields to a 3-bit ALU operation.
// Latency: combinational. Backpressure: none.
// Unaffected by ILLEGAL_TRAP_EN.
module multicycle_alu_ctl
    import multicycle_pkg::*;
(
    input  alu_op_t    i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op_b5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // funct7b5 only selects sub for register-register ops; addi ignores it
                    3'b000:  o_alu_control = (i_op_b5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore controller for the shared-memory multicycle RISC-V datapath (3-5 states per instruction).
// Latency: beq 3, R/I/jal/sw 4, lw 5 cycles with zero-wait memory. Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready.
// ILLEGAL_TRAP_EN: undecoded opcodes lock into TRAP with sticky illegal_instr; otherwise they retire as NOPs.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic       instr_retire,
    output logic       illegal_instr
);

    if (RESET_STATE_FETCH != 1'b1) begin : g_bad_reset_state
        $error("RESET_STATE_FETCH must stay 1");
    end

    state_t  r_state;
    state_t  w_state;
    state_t  w_next;
    alu_op_t w_alu_op;
    logic    w_pc_write, w_mem_write, w_ir_write, w_reg_write, w_retire, w_illegal;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= FETCH;
        else          r_state <= w_next;
    end

    always_comb begin
        // during reset the selects present FETCH values
        w_state     = reset_n ? r_state : FETCH;
        w_next      = w_state;
        adr_src     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        w_alu_op    = ALUOP_ADD;
        w_pc_write  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_retire    = 1'b0;
        w_illegal   = 1'b0;
        case (w_state)
            FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                if (mem_ready) w_next = DECODE;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_R:         w_next = EXECUTER;
                    OP_I:         w_next = EXECUTEI;
                    OP_JAL:       w_next = JAL;
                    OP_BEQ:       w_next = BEQ;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        w_next = TRAP;
`else
                        w_next   = FETCH;
                        w_retire = 1'b1;
`endif
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_next    = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) w_next = MEMWB;
            end
            MEMWB: begin
                result_src  = RES_DATA;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = FETCH;
            end
            MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = mem_ready;
                if (mem_ready) w_next = FETCH;
            end
            EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = ALUWB;
            end
            JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                w_pc_write = 1'b1;
                w_next     = ALUWB;
            end
            ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = FETCH;
            end
            BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                w_alu_op   = ALUOP_SUB;
                w_pc_write = zero;
                w_retire   = 1'b1;
                w_next     = FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: begin
                w_illegal = 1'b1;
                w_next    = TRAP;
            end
`endif
            default: w_next = FETCH;
        endcase
    end

    assign pc_write      = w_pc_write  & reset_n;
    assign mem_write     = w_mem_write & reset_n;
    assign ir_write      = w_ir_write  & reset_n;
    assign reg_write     = w_reg_write & reset_n;
    assign instr_retire  = w_retire    & reset_n;
    assign illegal_instr = w_illegal   & reset_n;
    assign imm_src       = imm_src_of(op);

    multicycle_alu_ctl u_alu_ctl (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op_b5       (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each cycle's expected control word is queued, then popped against the DUT.
// Honours ILLEGAL_TRAP_EN the same way as the design.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_retire, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int n_checks = 0;
    int n_errors = 0;
    logic [18:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .reg_write(reg_write), .alu_control(alu_control), .instr_retire(instr_retire),
        .illegal_instr(illegal_instr)
    );

    // {pcw, adr, memw, irw, result_src, src_a, src_b, imm_src, regw, alu_control, retire, illegal}
    function automatic logic [18:0] ev(input logic pcw, adr, memw, irw,
                                       input logic [1:0] rs, a, b, imm,
                                       input logic rw, input logic [2:0] alu,
                                       input logic ret, ill);
        return {pcw, adr, memw, irw, rs, a, b, imm, rw, alu, ret, ill};
    endfunction

    function automatic logic [18:0] got_vec();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                imm_src, reg_write, alu_control, instr_retire, illegal_instr};
    endfunction

    task automatic check_val(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %b exp %b (pcw adr memw irw rs a b imm rw alu ret ill)", tag, got, exp);
        end
    endtask

    // Queue the expected word at drive time, compare on the falling edge.
    task automatic step(input string tag, input logic [18:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        check_val(tag_q.pop_front(), got_vec(), exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] v_fetch(input logic [1:0] imm);
        return ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 0, 3'b000, 0, 0);
    endfunction
    function automatic logic [18:0] v_idle(input logic [1:0] imm);
        return ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 0, 3'b000, 0, 0);
    endfunction
    function automatic logic [18:0] v_decode(input logic [1:0] imm, input logic ret);
        return ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 0, 3'b000, ret, 0);
    endfunction
    function automatic logic [18:0] v_aluwb(input logic [1:0] imm);
        return ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 1, 3'b000, 1, 0);
    endfunction

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1; zero = 1'b0;
    endtask

    task automatic run_r(input string tag, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        set_instr(7'b0110011, f3, f7);
        step({tag, "_fetch"}, v_fetch(2'b00));
        step({tag, "_decode"}, v_decode(2'b00, 0));
        step({tag, "_exec"}, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, alu, 0, 0));
        step({tag, "_wb"}, v_aluwb(2'b00));
    endtask

    task automatic run_i(input string tag, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        set_instr(7'b0010011, f3, f7);
        step({tag, "_fetch"}, v_fetch(2'b00));
        step({tag, "_decode"}, v_decode(2'b00, 0));
        step({tag, "_exec"}, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, alu, 0, 0));
        step({tag, "_wb"}, v_aluwb(2'b00));
    endtask

    task automatic run_lw(input int stalls);
        set_instr(7'b0000011, 3'b010, 1'b0);
        step("lw_fetch", v_fetch(2'b00));
        step("lw_decode", v_decode(2'b00, 0));
        step("lw_memadr", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0, 0));
        for (int i = 0; i <= stalls; i++) begin
            mem_ready = (i == stalls);
            step("lw_memread", ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0, 0));
        end
        mem_ready = 1'b1;
        step("lw_memwb", ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000, 1, 0));
    endtask

    task automatic sw_head();
        set_instr(7'b0100011, 3'b010, 1'b0);
        step("sw_fetch", v_fetch(2'b01));
        step("sw_decode", v_decode(2'b01, 0));
        step("sw_memadr", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 0, 3'b000, 0, 0));
    endtask

    task automatic run_sw(input int stalls);
        sw_head();
        for (int i = 0; i <= stalls; i++) begin
            mem_ready = (i == stalls);
            step("sw_memwrite", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000, i == stalls, 0));
        end
        mem_ready = 1'b1;
    endtask

    task automatic run_beq(input logic z);
        set_instr(7'b1100011, 3'b000, 1'b0);
        step("beq_fetch", v_fetch(2'b10));
        step("beq_decode", v_decode(2'b10, 0));
        zero = z;
        step(z ? "beq_taken" : "beq_not_taken", ev(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001, 1, 0));
        zero = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        set_instr(7'b0000000, 3'b000, 1'b0);
        step("reset_0", v_idle(2'b00));
        step("reset_1", v_idle(2'b00));
        reset_n = 1'b1;

        run_r("add", 3'b000, 1'b0, 3'b000);
        run_r("sub", 3'b000, 1'b1, 3'b001);
        run_r("or",  3'b110, 1'b0, 3'b011);
        run_r("and", 3'b111, 1'b0, 3'b010);
        run_r("slt", 3'b010, 1'b0, 3'b101);
        run_i("addi_f7", 3'b000, 1'b1, 3'b000);
        run_i("slti", 3'b010, 1'b0, 3'b101);

        set_instr(7'b0110011, 3'b000, 1'b0);
        mem_ready = 1'b0;
        step("fetch_stall0", v_idle(2'b00));
        step("fetch_stall1", v_idle(2'b00));
        run_r("add_after_stall", 3'b000, 1'b0, 3'b000);

        run_lw(3);
        run_lw(0);
        run_sw(2);
        run_sw(0);
        run_beq(1'b1);
        run_beq(1'b0);

        set_instr(7'b1101111, 3'b000, 1'b0);
        step("jal_fetch", v_fetch(2'b11));
        step("jal_decode", v_decode(2'b11, 0));
        step("jal_jal", ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 0, 3'b000, 0, 0));
        step("jal_wb", v_aluwb(2'b11));

        // reset while a store is waiting on memory
        sw_head();
        mem_ready = 1'b0;
        step("sw_wait", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000, 0, 0));
        reset_n = 1'b0;
        step("sw_reset", v_idle(2'b01));
        reset_n = 1'b1;
        run_sw(0);

        set_instr(7'b1111111, 3'b000, 1'b0);
        step("ill_fetch", v_fetch(2'b00));
`ifdef ILLEGAL_TRAP_EN
        step("ill_decode", v_decode(2'b00, 0));
        for (int i = 0; i < 3; i++)
            step("ill_trap", ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0, 1));
        reset_n = 1'b0;
        step("ill_reset", v_idle(2'b00));
        reset_n = 1'b1;
        step("ill_refetch", v_fetch(2'b00));
`else
        step("ill_decode", v_decode(2'b00, 1));
        run_r("add_after_ill", 3'b000, 1'b0, 3'b000);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM that sequences the shared multicycle RISC-V datapath: one unified instruction/data memory, one ALU, instruction register, old-PC register.
- Executes lw, sw, R-type, I-type ALU, jal and beq over 3–5 states per instruction.
- Stalls on a memory ready handshake.
- Sits beside the datapath in the multicycle top; replaces the single-cycle control path.

Parameters:
- RESET_STATE_FETCH, 1, must stay 1; FSM leaves reset in FETCH (kept for lint/elaboration checks only).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- op  input  7  instr[6:0] from instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory accepted write / read data valid this cycle
- pc_write  output  1  PC register enable
- adr_src  output  1  0 = PC, 1 = ALU result register
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register and old-PC enable
- result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  output  2  00 rs2, 01 ImmExt, 10 constant 4
- imm_src  output  2  00 I, 01 S, 10 B, 11 J
- reg_write  output  1  register file write enable
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_retire  output  1  one-cycle pulse when an instruction completes
- illegal_instr  output  1  sticky illegal-opcode flag (see Optional Feature)

Behaviour:
- Opcodes:
  - lw 0000011
  - sw 0100011
  - R 0110011
  - I 0010011
  - jal 1101111
  - beq 1100011
- State register updates only on rising clk.
- While reset_n = 0:
  - state ← FETCH next edge.
  - pc_write, mem_write, ir_write, reg_write, instr_retire, illegal_instr all forced 0 (combinationally, also in the reset cycle).
  - Select outputs show FETCH values.
- Outputs are Moore (decode of state) except:
  - pc_write includes the branch term.
  - ir_write / pc_write in FETCH are gated by mem_ready.
- Unlisted selects are 00 / 0.
- alu_op (internal): 00 add, 01 sub, 10 funct decode.
- alu_control decode:
  - alu_op 00 → add; 01 → sub.
  - alu_op 10: funct3 000 → sub if op[5] & funct7b5, else add.
  - funct3 010 slt, 110 or, 111 and; others add.
- imm_src is combinational from op: lw/I 00, sw 01, beq 10, jal 11, other 00.
- States and transitions:
  - FETCH: adr_src 0, a 00, b 10, alu_op 00, result_src 10.
    - mem_ready = 1 → ir_write = 1, pc_write = 1, next DECODE.
    - mem_ready = 0 → hold FETCH, no enables.
  - DECODE: a 01, b 01, alu_op 00.
    - lw/sw → MEMADR; R → EXECUTER; I → EXECUTEI; jal → JAL; beq → BEQ; other → ILLEGAL handling.
  - MEMADR: a 10, b 01, alu_op 00. Next MEMREAD if op[5] = 0, else MEMWRITE.
  - MEMREAD: adr_src 1. Hold until mem_ready, then MEMWB.
  - MEMWB: result_src 01, reg_write 1, instr_retire 1 → FETCH.
  - MEMWRITE: adr_src 1, mem_write 1, held asserted until mem_ready; on mem_ready instr_retire 1 → FETCH.
  - EXECUTER: a 10, b 00, alu_op 10 → ALUWB.
  - EXECUTEI: a 10, b 01, alu_op 10 → ALUWB.
  - JAL: a 01, b 10, alu_op 00, result_src 00, pc_write 1 → ALUWB.
  - ALUWB: result_src 00, reg_write 1, instr_retire 1 → FETCH.
  - BEQ: a 10, b 00, alu_op 01, result_src 00, pc_write = zero, instr_retire 1 → FETCH.
- Boundary cases:
  - mem_ready may be held high permanently (zero-wait memory); the FSM never waits.
  - reset_n low in any state, including a mid-MEMWRITE wait: mem_write drops in that cycle and the FSM resumes in FETCH.
- CPI with zero-wait memory: beq 3, R/I/jal/sw 4, lw 5.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - Undecoded opcode in DECODE → state TRAP.
  - illegal_instr = 1 sticky, all enables 0, FSM stays in TRAP until reset_n = 0.
- Undefined:
  - Undecoded opcode → FETCH as a NOP with instr_retire 1 in DECODE.
  - TRAP state absent; illegal_instr tied 0.

Decomposition:
- Package multicycle_pkg holds:
  - state_t enum (FETCH…TRAP).
  - Opcode localparams.
  - alu_op and alu_control encodings.
  - result_src / src_a / src_b encodings.
- One sub-module: multicycle_alu_ctl (combinational alu_op/funct → alu_control); the FSM lives in the top.

Test Plan:
- Reset: reset_n = 0 for 2 cycles with mem_ready = 1 → all enables 0; first cycle after release is FETCH with ir_write = 1, pc_write = 1.
- add x3,x1,x2 (op 0110011, funct3 000, f7b5 0), mem_ready = 1:
  - States FETCH, DECODE, EXECUTER, ALUWB.
  - alu_control 000 in EXECUTER; reg_write = 1 and instr_retire = 1 in cycle 4.
  - With f7b5 = 1: alu_control 001.
- lw with mem_ready low for 3 cycles in MEMREAD → FSM holds MEMREAD 4 cycles; MEMWB follows with result_src 01, reg_write 1.
- sw with mem_ready = 0 for 2 cycles → mem_write high 3 consecutive cycles, adr_src 1, imm_src 01; then FETCH.
- beq:
  - zero = 1 → pc_write = 1 in BEQ, alu_control 001.
  - zero = 0 → pc_write = 0.
  - Both cases take 3 cycles.
- Opcode 1111111:
  - With ILLEGAL_TRAP_EN: illegal_instr rises after DECODE and stays 1; only reset_n clears it.
  - Without: returns to FETCH, no reg_write or mem_write.
